// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared types and constants for the sprite motion controller:
//   FSM state encoding, screen/sprite geometry, coordinate widths.
package sprite_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SPRITE_W  = 64;
  localparam int SPRITE_H  = 32;

  // Largest top-left coordinate that keeps the whole sprite on screen.
  localparam int DEF_MAX_X = SCREEN_W - SPRITE_W;
  localparam int DEF_MAX_Y = SCREEN_H - SPRITE_H;

  localparam int COORD_W   = 10;
  // One extra bit so pos + speed never wraps before the wall compare.
  localparam int WIDE_W    = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [WIDE_W-1:0]  wide_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if
//   Bundles the frame-tick/control inputs and the committed sprite state
//   outputs of sprite_motion_ctrl.
//   master: drives frame_tick, pause, speed; observes the outputs.
//   slave : the controller itself.
interface sprite_motion_ctrl_if;
  import sprite_pkg::*;

  logic        frame_tick;
  logic        pause;
  logic [2:0]  speed;
  coord_t      sprite_x;
  coord_t      sprite_y;
  logic        dir_x;
  logic        dir_y;
  logic [3:0]  scene;
  logic        bounce;
  logic        corner;
  logic [15:0] frame_count;
  logic        busy;
  logic        tick_drop;

  modport master (
    output frame_tick, pause, speed,
    input  sprite_x, sprite_y, dir_x, dir_y, scene, bounce, corner,
           frame_count, busy, tick_drop
  );

  modport slave (
    input  frame_tick, pause, speed,
    output sprite_x, sprite_y, dir_x, dir_y, scene, bounce, corner,
           frame_count, busy, tick_drop
  );

endinterface

// File: rtl/sprite_axis_step.sv
// sprite_axis_step
//   Combinational bounded step of one axis.
//   pos/dir/max_pos : current coordinate, direction (1 = increasing), wall
//   speed/pause     : step size 0..7 and freeze flag
//   npos/ndir/hit   : next coordinate, next direction, wall-hit flag
module sprite_axis_step
  import sprite_pkg::*;
(
  input  coord_t     pos,
  input  logic       dir,
  input  coord_t     max_pos,
  input  logic [2:0] speed,
  input  logic       pause,
  output coord_t     npos,
  output logic       ndir,
  output logic       hit
);

  wide_t pos_w;
  wide_t spd_w;
  wide_t max_w;
  wide_t sum_w;

  // Clamp-and-reflect step; compares done at 11 bits so nothing wraps.
  always_comb begin
    pos_w = {1'b0, pos};
    spd_w = {8'd0, speed};
    max_w = {1'b0, max_pos};
    sum_w = pos_w + spd_w;
    npos  = pos;
    ndir  = dir;
    hit   = 1'b0;
    if (pause || (speed == 3'd0)) begin
      npos = pos;
    end else if (dir) begin
      if (sum_w >= max_w) begin
        npos = max_pos;
        ndir = 1'b0;
        hit  = 1'b1;
      end else begin
        npos = sum_w[COORD_W-1:0];
      end
    end else begin
      if (pos_w <= spd_w) begin
        npos = '0;
        ndir = 1'b1;
        hit  = 1'b1;
      end else begin
        npos = pos - {7'd0, speed};
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Once per frame_tick, steps X then Y through one shared sprite_axis_step
//   into shadow registers, then commits both axes, directions, scene and
//   frame counter on a single edge so the renderer never sees a half update.
//   clk, rst_n : single clock, async active-low reset
//   bus        : frame_tick/pause/speed in; committed sprite state out
module sprite_motion_ctrl #(
  parameter int MAX_X  = sprite_pkg::DEF_MAX_X,
  parameter int MAX_Y  = sprite_pkg::DEF_MAX_Y,
  parameter int INIT_X = 50,   // 0 <= INIT_X <= MAX_X
  parameter int INIT_Y = 50    // 0 <= INIT_Y <= MAX_Y
) (
  input  logic                clk,
  input  logic                rst_n,
  sprite_motion_ctrl_if.slave bus
);
  import sprite_pkg::*;

  localparam coord_t MaxXC  = coord_t'(MAX_X);
  localparam coord_t MaxYC  = coord_t'(MAX_Y);
  localparam coord_t InitXC = coord_t'(INIT_X);
  localparam coord_t InitYC = coord_t'(INIT_Y);

  state_e      state_q, state_d;
  logic [2:0]  speed_q, speed_d;
  logic        pause_q, pause_d;
  coord_t      nx_q, nx_d, ny_q, ny_d;
  logic        ndx_q, ndx_d, ndy_q, ndy_d;
  logic        hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  coord_t      x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [3:0]  scene_q, scene_d;
  logic        bounce_q, bounce_d, corner_q, corner_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        busy_q, busy_d;
  logic        tick_drop_q, tick_drop_d;

  coord_t      step_pos_s, step_max_s, step_npos_s;
  logic        step_dir_s, step_ndir_s, step_hit_s;

  // Time-multiplex the shared stepper: Y operands only during STEP_Y.
  always_comb begin
    if (state_q == STEP_Y) begin
      step_pos_s = y_q;
      step_dir_s = dir_y_q;
      step_max_s = MaxYC;
    end else begin
      step_pos_s = x_q;
      step_dir_s = dir_x_q;
      step_max_s = MaxXC;
    end
  end

  sprite_axis_step u_step (
    .pos     (step_pos_s),
    .dir     (step_dir_s),
    .max_pos (step_max_s),
    .speed   (speed_q),
    .pause   (pause_q),
    .npos    (step_npos_s),
    .ndir    (step_ndir_s),
    .hit     (step_hit_s)
  );

  // Next-state and next-output logic for the per-frame update sequence.
  always_comb begin
    state_d       = state_q;
    speed_d       = speed_q;
    pause_d       = pause_q;
    nx_d          = nx_q;
    ndx_d         = ndx_q;
    hit_x_d       = hit_x_q;
    ny_d          = ny_q;
    ndy_d         = ndy_q;
    hit_y_d       = hit_y_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    scene_d       = scene_q;
    frame_count_d = frame_count_q;
    bounce_d      = 1'b0;
    corner_d      = 1'b0;
    // A tick arriving mid-update is dropped, never restarts the update.
    tick_drop_d   = bus.frame_tick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          state_d = STEP_X;
          speed_d = bus.speed;
          pause_d = bus.pause;
        end else begin
          state_d = IDLE;
        end
      end
      STEP_X: begin
        nx_d    = step_npos_s;
        ndx_d   = step_ndir_s;
        hit_x_d = step_hit_s;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        ny_d    = step_npos_s;
        ndy_d   = step_ndir_s;
        hit_y_d = step_hit_s;
        state_d = COMMIT;
      end
      COMMIT: begin
        x_d           = nx_q;
        y_d           = ny_q;
        dir_x_d       = ndx_q;
        dir_y_d       = ndy_q;
        frame_count_d = frame_count_q + 16'd1;
        // A corner hit still advances the scene by exactly one.
        if (hit_x_q || hit_y_q) begin
          scene_d  = scene_q + 4'd1;
          bounce_d = 1'b1;
        end else begin
          scene_d  = scene_q;
        end
        corner_d = hit_x_q && hit_y_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, shadow and committed output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      speed_q       <= 3'd0;
      pause_q       <= 1'b0;
      nx_q          <= '0;
      ndx_q         <= 1'b1;
      hit_x_q       <= 1'b0;
      ny_q          <= '0;
      ndy_q         <= 1'b1;
      hit_y_q       <= 1'b0;
      x_q           <= InitXC;
      y_q           <= InitYC;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      scene_q       <= 4'd0;
      bounce_q      <= 1'b0;
      corner_q      <= 1'b0;
      frame_count_q <= 16'd0;
      busy_q        <= 1'b0;
      tick_drop_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      speed_q       <= speed_d;
      pause_q       <= pause_d;
      nx_q          <= nx_d;
      ndx_q         <= ndx_d;
      hit_x_q       <= hit_x_d;
      ny_q          <= ny_d;
      ndy_q         <= ndy_d;
      hit_y_q       <= hit_y_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      scene_q       <= scene_d;
      bounce_q      <= bounce_d;
      corner_q      <= corner_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      tick_drop_q   <= tick_drop_d;
    end
  end

  assign bus.sprite_x    = x_q;
  assign bus.sprite_y    = y_q;
  assign bus.dir_x       = dir_x_q;
  assign bus.dir_y       = dir_y_q;
  assign bus.scene       = scene_q;
  assign bus.bounce      = bounce_q;
  assign bus.corner      = corner_q;
  assign bus.frame_count = frame_count_q;
  assign bus.busy        = busy_q;
  assign bus.tick_drop   = tick_drop_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl
//   Directed bench. Four controller instances share clock, reset and the
//   tick/pause/speed stimulus; each scenario checks the instance whose
//   parameters set up its starting position.
module tb_sprite_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       pause;
  logic [2:0] speed;
  int         checks;
  int         errors;

  sprite_motion_ctrl_if if_a ();  // default 50,50
  sprite_motion_ctrl_if if_b ();  // starts near right wall
  sprite_motion_ctrl_if if_c ();  // narrow field MAX_X=10
  sprite_motion_ctrl_if if_d ();  // starts in bottom-right corner

  assign if_a.frame_tick = tick;
  assign if_a.pause      = pause;
  assign if_a.speed      = speed;
  assign if_b.frame_tick = tick;
  assign if_b.pause      = pause;
  assign if_b.speed      = speed;
  assign if_c.frame_tick = tick;
  assign if_c.pause      = pause;
  assign if_c.speed      = speed;
  assign if_d.frame_tick = tick;
  assign if_d.pause      = pause;
  assign if_d.speed      = speed;

  sprite_motion_ctrl dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  sprite_motion_ctrl #(.INIT_X(574), .INIT_Y(50)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  sprite_motion_ctrl #(.MAX_X(10), .MAX_Y(448), .INIT_X(10), .INIT_Y(50))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  sprite_motion_ctrl #(.INIT_X(576), .INIT_Y(448)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    pause = 1'b0;
    speed = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One accepted tick; returns 1 time unit after the commit edge E3.
  task automatic run_frame(input logic [2:0] spd);
    speed = spd;
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (if_a.sprite_x !== 10'd50) begin errors++; $display("FAIL reset_x got %0d exp 50", if_a.sprite_x); end
    checks++; if (if_a.sprite_y !== 10'd50) begin errors++; $display("FAIL reset_y got %0d exp 50", if_a.sprite_y); end
    checks++; if ({if_a.dir_x, if_a.dir_y} !== 2'b11) begin errors++; $display("FAIL reset_dir got %b exp 11", {if_a.dir_x, if_a.dir_y}); end
    checks++; if ({if_a.scene, if_a.frame_count} !== 20'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", if_a.scene, if_a.frame_count); end
    checks++; if ({if_a.bounce, if_a.corner, if_a.busy, if_a.tick_drop} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {if_a.bounce, if_a.corner, if_a.busy, if_a.tick_drop}); end
  endtask

  task automatic test_basic_motion();
    int exp_v;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      speed = 3'd1;
      @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);                 // E0
      #1 tick = 1'b0;
      checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", if_a.busy); end
      repeat (2) @(posedge clk);      // E1, E2
      #1;
      exp_v = 50 + i;
      checks++; if (if_a.sprite_x !== 10'(exp_v)) begin errors++; $display("FAIL basic_early_x got %0d exp %0d", if_a.sprite_x, exp_v); end
      @(posedge clk);                 // E3
      #1;
      exp_v = 51 + i;
      checks++; if (if_a.sprite_x !== 10'(exp_v) || if_a.sprite_y !== 10'(exp_v)) begin
        errors++; $display("FAIL basic_xy got %0d,%0d exp %0d,%0d", if_a.sprite_x, if_a.sprite_y, exp_v, exp_v); end
      checks++; if (if_a.bounce !== 1'b0) begin errors++; $display("FAIL basic_bounce got %b exp 0", if_a.bounce); end
      @(posedge clk);
      #1;
      checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", if_a.busy); end
      repeat (95) @(posedge clk);
    end
    checks++; if (if_a.sprite_x !== 10'd55 || if_a.sprite_y !== 10'd55) begin
      errors++; $display("FAIL basic_final_xy got %0d,%0d exp 55,55", if_a.sprite_x, if_a.sprite_y); end
    checks++; if (if_a.frame_count !== 16'd5) begin errors++; $display("FAIL basic_fc got %0d exp 5", if_a.frame_count); end
    checks++; if (if_a.scene !== 4'd0) begin errors++; $display("FAIL basic_scene got %0d exp 0", if_a.scene); end
  endtask

  task automatic test_right_wall();
    apply_reset();
    run_frame(3'd3);
    checks++; if (if_b.sprite_x !== 10'd576 || if_b.dir_x !== 1'b0) begin
      errors++; $display("FAIL rwall_x got %0d dir %b exp 576 dir 0", if_b.sprite_x, if_b.dir_x); end
    checks++; if (if_b.bounce !== 1'b1 || if_b.scene !== 4'd1 || if_b.corner !== 1'b0) begin
      errors++; $display("FAIL rwall_flags got b%b s%0d c%b exp b1 s1 c0", if_b.bounce, if_b.scene, if_b.corner); end
    run_frame(3'd3);
    checks++; if (if_b.sprite_x !== 10'd573 || if_b.sprite_y !== 10'd56) begin
      errors++; $display("FAIL rwall_next got %0d,%0d exp 573,56", if_b.sprite_x, if_b.sprite_y); end
    checks++; if (if_b.bounce !== 1'b0 || if_b.scene !== 4'd1) begin
      errors++; $display("FAIL rwall_next_flags got b%b s%0d exp b0 s1", if_b.bounce, if_b.scene); end
  endtask

  task automatic test_left_wall();
    logic [2:0] spds [9];
    spds = '{3'd4, 3'd4, 3'd4, 3'd2, 3'd7, 3'd3, 3'd7, 3'd2, 3'd7};
    apply_reset();
    // 10 -> 10(hit, turn) -> 6 -> 2 -> 0(hit)
    for (int i = 0; i < 4; i++) run_frame(spds[i]);
    checks++; if (if_c.sprite_x !== 10'd0 || if_c.dir_x !== 1'b1 || if_c.bounce !== 1'b1) begin
      errors++; $display("FAIL lwall_exact got %0d dir %b b%b exp 0 dir 1 b1", if_c.sprite_x, if_c.dir_x, if_c.bounce); end
    checks++; if (if_c.scene !== 4'd2) begin errors++; $display("FAIL lwall_scene got %0d exp 2", if_c.scene); end
    // 0 -> 7 -> 10(hit) -> 3 -> 1, still moving left
    for (int i = 4; i < 8; i++) run_frame(spds[i]);
    checks++; if (if_c.sprite_x !== 10'd1 || if_c.dir_x !== 1'b0) begin
      errors++; $display("FAIL lwall_pre got %0d dir %b exp 1 dir 0", if_c.sprite_x, if_c.dir_x); end
    run_frame(spds[8]);
    checks++; if (if_c.sprite_x !== 10'd0 || if_c.dir_x !== 1'b1 || if_c.scene !== 4'd4) begin
      errors++; $display("FAIL lwall_underflow got %0d dir %b s%0d exp 0 dir 1 s4", if_c.sprite_x, if_c.dir_x, if_c.scene); end
    checks++; if (if_c.sprite_y !== 10'd90) begin errors++; $display("FAIL lwall_y got %0d exp 90", if_c.sprite_y); end
  endtask

  task automatic test_corner();
    apply_reset();
    run_frame(3'd1);
    checks++; if (if_d.corner !== 1'b1 || if_d.bounce !== 1'b1) begin
      errors++; $display("FAIL corner_pulse got c%b b%b exp c1 b1", if_d.corner, if_d.bounce); end
    checks++; if (if_d.scene !== 4'd1) begin errors++; $display("FAIL corner_scene got %0d exp 1", if_d.scene); end
    checks++; if ({if_d.dir_x, if_d.dir_y} !== 2'b00 || if_d.sprite_x !== 10'd576 || if_d.sprite_y !== 10'd448) begin
      errors++; $display("FAIL corner_pos got %0d,%0d dirs %b exp 576,448 dirs 00", if_d.sprite_x, if_d.sprite_y, {if_d.dir_x, if_d.dir_y}); end
    @(posedge clk);
    #1;
    checks++; if (if_d.corner !== 1'b0 || if_d.bounce !== 1'b0) begin
      errors++; $display("FAIL corner_width got c%b b%b exp c0 b0", if_d.corner, if_d.bounce); end
  endtask

  task automatic test_pause_and_drop();
    apply_reset();
    speed = 3'd3;
    pause = 1'b1;
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);                   // E0
    #1 tick = 1'b0;
    pause = 1'b0;
    @(posedge clk);                   // E1
    #1 tick = 1'b1;
    @(posedge clk);                   // E2: tick seen while busy
    #1 tick = 1'b0;
    checks++; if (if_a.tick_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", if_a.tick_drop); end
    @(posedge clk);                   // E3
    #1;
    checks++; if (if_a.tick_drop !== 1'b0) begin errors++; $display("FAIL drop_width got %b exp 0", if_a.tick_drop); end
    checks++; if (if_a.sprite_x !== 10'd50 || if_a.sprite_y !== 10'd50) begin
      errors++; $display("FAIL pause_pos got %0d,%0d exp 50,50", if_a.sprite_x, if_a.sprite_y); end
    checks++; if (if_a.frame_count !== 16'd1) begin errors++; $display("FAIL pause_fc got %0d exp 1", if_a.frame_count); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (if_a.frame_count !== 16'd1 || if_a.busy !== 1'b0) begin
      errors++; $display("FAIL drop_nocommit got fc %0d busy %b exp 1 0", if_a.frame_count, if_a.busy); end
  endtask

  task automatic test_reset_mid_update();
    apply_reset();
    run_frame(3'd2);
    run_frame(3'd2);
    checks++; if (if_a.sprite_x !== 10'd54 || if_a.frame_count !== 16'd2) begin
      errors++; $display("FAIL mid_setup got %0d fc %0d exp 54 fc 2", if_a.sprite_x, if_a.frame_count); end
    speed = 3'd2;
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);                   // E0
    #1 tick = 1'b0;
    @(posedge clk);                   // E1, now in STEP_Y
    #1 rst_n = 1'b0;
    #1;
    checks++; if (if_a.sprite_x !== 10'd50 || if_a.sprite_y !== 10'd50 || {if_a.dir_x, if_a.dir_y} !== 2'b11) begin
      errors++; $display("FAIL mid_pos got %0d,%0d dirs %b exp 50,50 dirs 11", if_a.sprite_x, if_a.sprite_y, {if_a.dir_x, if_a.dir_y}); end
    checks++; if (if_a.scene !== 4'd0 || if_a.busy !== 1'b0 || if_a.frame_count !== 16'd0) begin
      errors++; $display("FAIL mid_state got s%0d busy %b fc %0d exp s0 busy 0 fc 0", if_a.scene, if_a.busy, if_a.frame_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if_a.sprite_x !== 10'd50 || if_a.busy !== 1'b0) begin
      errors++; $display("FAIL mid_hold got %0d busy %b exp 50 busy 0", if_a.sprite_x, if_a.busy); end
    run_frame(3'd2);
    checks++; if (if_a.sprite_x !== 10'd52 || if_a.sprite_y !== 10'd52 || if_a.frame_count !== 16'd1) begin
      errors++; $display("FAIL mid_after got %0d,%0d fc %0d exp 52,52 fc 1", if_a.sprite_x, if_a.sprite_y, if_a.frame_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    tick   = 1'b0;
    pause  = 1'b0;
    speed  = 3'd0;
    test_reset();
    test_basic_motion();
    test_right_wall();
    test_left_wall();
    test_corner();
    test_pause_and_drop();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
